// File: rtl/fifo_relay_mc.sv
// Multi-channel FWFT relay FIFO: pipelined forward/ready paths with a skid-absorbing landing buffer per channel.
// Optional sticky overflow/underflow detection is enabled by defining FIFO_RELAY_MC_ERR_EN.
module fifo_relay_mc #(
   parameter int DATA_WIDTH = 512,
   parameter int NUM_CH     = 4,
   parameter int DEPTH      = 8,
   parameter int PIPE_LEVEL = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0]          s_data,
   input  logic [NUM_CH-1:0]                     s_data_vld,
   output logic [NUM_CH-1:0]                     s_read,
   output logic [NUM_CH*DATA_WIDTH-1:0]          m_data,
   output logic [NUM_CH-1:0]                     m_data_vld,
   input  logic [NUM_CH-1:0]                     m_read,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   occupancy,
   output logic [NUM_CH-1:0]                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FULL_CNT  = OW'(DEPTH);
   // Leaves room for every word that can still be in flight once ready drops.
   localparam logic [OW-1:0] READY_THR = OW'(DEPTH - 2*PIPE_LEVEL);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] wr_data;
         logic                  wr_vld;
         logic                  ready_raw;
         logic                  pop;
         logic                  push;
         logic [AW-1:0]         wr_ptr_reg;
         logic [AW-1:0]         rd_ptr_reg;
         logic [OW-1:0]         occ_reg;
         logic [DATA_WIDTH-1:0] mem [DEPTH];

         if (PIPE_LEVEL > 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] data_reg [PIPE_LEVEL];
            logic [PIPE_LEVEL-1:0] vld_reg;
            logic [PIPE_LEVEL-1:0] rdy_reg;

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  vld_reg <= '0;
                  rdy_reg <= '0;
               end else begin
                  vld_reg[0] <= s_data_vld[gi];
                  rdy_reg[0] <= ready_raw;
                  for (int k = 1; k < PIPE_LEVEL; k++) begin
                     vld_reg[k] <= vld_reg[k-1];
                     rdy_reg[k] <= rdy_reg[k-1];
                  end
               end
            end

            // Payload stages carry no reset; the valid bits qualify them.
            always_ff @(posedge clk) begin
               data_reg[0] <= s_data[gi*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < PIPE_LEVEL; k++) begin
                  data_reg[k] <= data_reg[k-1];
               end
            end

            assign wr_vld     = vld_reg[PIPE_LEVEL-1];
            assign wr_data    = data_reg[PIPE_LEVEL-1];
            assign s_read[gi] = rdy_reg[PIPE_LEVEL-1];
         end else begin : g_nopipe
            assign wr_vld     = s_data_vld[gi];
            assign wr_data    = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_read[gi] = ready_raw & ~rst;
         end

         assign ready_raw = (occ_reg < READY_THR);
         assign pop       = m_read[gi] && (occ_reg != '0);
         // A full buffer still accepts a word when the head leaves on the same edge.
         assign push      = wr_vld && ((occ_reg != FULL_CNT) || pop);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               occ_reg    <= '0;
            end else begin
               if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
               if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
               if (push && !pop)      occ_reg <= occ_reg + OW'(1);
               else if (pop && !push) occ_reg <= occ_reg - OW'(1);
            end
         end

         always_ff @(posedge clk) begin
            if (push) mem[wr_ptr_reg] <= wr_data;
         end

         assign m_data_vld[gi]                        = (occ_reg != '0);
         assign m_data[gi*DATA_WIDTH +: DATA_WIDTH]   = m_data_vld[gi] ? mem[rd_ptr_reg] : '0;
         assign occupancy[gi*OW +: OW]                = occ_reg;

`ifdef FIFO_RELAY_MC_ERR_EN
         logic err_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               err_reg <= 1'b0;
            end else if ((wr_vld && (occ_reg == FULL_CNT) && !pop) ||
                         (m_read[gi] && (occ_reg == '0))) begin
               err_reg <= 1'b1;
            end
         end
         assign err[gi] = err_reg;
`else
         assign err[gi] = 1'b0;
`endif
      end
   endgenerate

endmodule
